// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational ROM read port between
// instruction fetch (IF, requester 0) and the data/debug side (DM,
// requester 1). Round-robin on contention, registered read data with
// 1-cycle latency, IF response flush and a saturating contention counter.
module rom_port_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch side
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_gnt,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [DWIDTH-1:0] if_rdata,
    // data / debug side
    input  logic              dm_req,
    input  logic [AWIDTH-1:0] dm_addr,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DWIDTH-1:0] dm_rdata,
    // ROM read port
    output logic [AWIDTH-1:0] rom_raddr,
    input  logic [DWIDTH-1:0] rom_dout,
    // statistics
    output logic [CWIDTH-1:0] conflict_cnt
);

    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

    // Requester that won the most recent grant: 0 = IF, 1 = DM.
    logic              r_last_gnt;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;
    logic [DWIDTH-1:0] r_if_rdata;
    logic [DWIDTH-1:0] r_dm_rdata;
    logic [CWIDTH-1:0] r_conflict_cnt;

    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_contend;

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that did not win last time gets the port.
    always_comb begin
        w_contend = if_req & dm_req;
        w_if_gnt  = if_req & (~dm_req | r_last_gnt);
        w_dm_gnt  = dm_req & (~if_req | ~r_last_gnt);
    end

    assign if_gnt       = w_if_gnt;
    assign dm_gnt       = w_dm_gnt;
    // Idle cycles pass if_addr through; ROM reads have no side effects.
    assign rom_raddr    = w_dm_gnt ? dm_addr : if_addr;
    assign if_rvalid    = r_if_rvalid;
    assign if_rdata     = r_if_rdata;
    assign dm_rvalid    = r_dm_rvalid;
    assign dm_rdata     = r_dm_rdata;
    assign conflict_cnt = r_conflict_cnt;

    // Track last winner; reset to DM so IF wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_gnt <= 1'b1;
        else if (w_if_gnt)
            r_last_gnt <= 1'b0;
        else if (w_dm_gnt)
            r_last_gnt <= 1'b1;
    end

    // IF response: capture on grant unless flushed; flush still counts as a grant above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_if_gnt & ~if_flush;
            if (w_if_gnt && !if_flush)
                r_if_rdata <= rom_dout;
        end
    end

    // DM response: capture on every DM grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            r_dm_rvalid <= w_dm_gnt;
            if (w_dm_gnt)
                r_dm_rdata <= rom_dout;
        end
    end

    // Saturating count of cycles where both sides requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_conflict_cnt <= '0;
        else if (w_contend && (r_conflict_cnt != CNT_MAX))
            r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter. A second instance with CWIDTH=4
// shares the stimulus so counter saturation can be observed.
module tb_rom_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          if_req, if_flush, dm_req;
    logic [AW-1:0] if_addr, dm_addr;

    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata, rom_dout;
    logic [AW-1:0] rom_raddr;
    logic [15:0]   conflict_cnt;

    logic          s_if_gnt, s_if_rvalid, s_dm_gnt, s_dm_rvalid;
    logic [DW-1:0] s_if_rdata, s_dm_rdata, s_rom_dout;
    logic [AW-1:0] s_rom_raddr;
    logic [3:0]    s_conflict_cnt;

    int checks = 0;
    int errors = 0;

    // ROM image: distinct, address-derived word per location.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {a, 6'h00, a, 6'h2A};
    endfunction

    assign rom_dout   = rom(rom_raddr);
    assign s_rom_dout = rom(s_rom_raddr);

    rom_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .rom_raddr(rom_raddr), .rom_dout(rom_dout), .conflict_cnt(conflict_cnt)
    );

    rom_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt), .if_flush(if_flush),
        .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(s_dm_gnt),
        .dm_rvalid(s_dm_rvalid), .dm_rdata(s_dm_rdata),
        .rom_raddr(s_rom_raddr), .rom_dout(s_rom_dout), .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
        if_addr = '0; dm_addr = '0;
        tick(); tick();
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        rst_n = 1'b1;

        // Single IF read
        if_req = 1'b1; if_addr = 10'h005;
        #1;
        chk("t1_if_gnt", 32'(if_gnt), 32'd1);
        chk("t1_dm_gnt", 32'(dm_gnt), 32'd0);
        chk("t1_raddr", 32'(rom_raddr), 32'h005);
        tick();
        if_req = 1'b0;
        chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t1_if_rdata", if_rdata, rom(10'h005));
        chk("t1_dm_rvalid", 32'(dm_rvalid), 32'd0);
        tick();
        chk("t1_if_rvalid_off", 32'(if_rvalid), 32'd0);

        // Back-to-back IF reads
        if_req = 1'b1; if_addr = 10'h001;
        tick();
        chk("b2b_rv1", 32'(if_rvalid), 32'd1);
        chk("b2b_rd1", if_rdata, rom(10'h001));
        if_addr = 10'h002;
        tick();
        chk("b2b_rv2", 32'(if_rvalid), 32'd1);
        chk("b2b_rd2", if_rdata, rom(10'h002));
        if_addr = 10'h003;
        tick();
        chk("b2b_rv3", 32'(if_rvalid), 32'd1);
        chk("b2b_rd3", if_rdata, rom(10'h003));
        if_req = 1'b0;
        tick();
        chk("b2b_rv_off", 32'(if_rvalid), 32'd0);

        // Round robin from reset
        rst_n = 1'b0; #2; rst_n = 1'b1;
        if_req = 1'b1; if_addr = 10'h010; dm_req = 1'b1; dm_addr = 10'h020;
        #1;
        chk("rr_g0_if", 32'(if_gnt), 32'd1);
        chk("rr_g0_dm", 32'(dm_gnt), 32'd0);
        chk("rr_g0_addr", 32'(rom_raddr), 32'h010);
        tick();
        chk("rr_r0_ifv", 32'(if_rvalid), 32'd1);
        chk("rr_r0_ifd", if_rdata, rom(10'h010));
        chk("rr_r0_dmv", 32'(dm_rvalid), 32'd0);
        chk("rr_g1_dm", 32'(dm_gnt), 32'd1);
        chk("rr_g1_if", 32'(if_gnt), 32'd0);
        chk("rr_g1_addr", 32'(rom_raddr), 32'h020);
        tick();
        chk("rr_r1_dmv", 32'(dm_rvalid), 32'd1);
        chk("rr_r1_dmd", dm_rdata, rom(10'h020));
        chk("rr_r1_ifv", 32'(if_rvalid), 32'd0);
        chk("rr_g2_if", 32'(if_gnt), 32'd1);
        tick();
        chk("rr_r2_ifv", 32'(if_rvalid), 32'd1);
        chk("rr_g3_dm", 32'(dm_gnt), 32'd1);
        tick();
        if_req = 1'b0; dm_req = 1'b0;
        chk("rr_r3_dmv", 32'(dm_rvalid), 32'd1);
        chk("rr_cnt4", 32'(conflict_cnt), 32'd4);
        chk("rr_cnt4_sat", 32'(s_conflict_cnt), 32'd4);

        // Flush on an IF grant
        if_req = 1'b1; if_addr = 10'h007; if_flush = 1'b1;
        #1;
        chk("fl_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        chk("fl_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("fl_if_rdata", if_rdata, rom(10'h010));
        if_req = 1'b0; dm_req = 1'b1; dm_addr = 10'h030;
        #1;
        chk("fl_dm_gnt", 32'(dm_gnt), 32'd1);
        tick();
        dm_req = 1'b0; if_flush = 1'b0;
        chk("fl_dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("fl_dm_rdata", dm_rdata, rom(10'h030));
        chk("fl_cnt_hold", 32'(conflict_cnt), 32'd4);

        // Asynchronous reset in the cycle after a DM grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("ar_cnt", 32'(conflict_cnt), 32'd0);
        chk("ar_dm_rdata", dm_rdata, 32'd0);
        #1;
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 10'h040; dm_req = 1'b1; dm_addr = 10'h050;
        #1;
        chk("ar_first_if", 32'(if_gnt), 32'd1);
        chk("ar_first_dm", 32'(dm_gnt), 32'd0);

        // Saturation of the 4-bit counter over 20 contended cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_alt", 32'(if_gnt), ((i + 1) % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 14) chk("sat_at15", 32'(s_conflict_cnt), 32'd15);
        end
        chk("sat_hold15", 32'(s_conflict_cnt), 32'd15);
        chk("sat_cnt16_20", 32'(conflict_cnt), 32'd20);
        tick();
        chk("sat_still15", 32'(s_conflict_cnt), 32'd15);
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        tick();
        chk("sat_idle_cnt", 32'(conflict_cnt), 32'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
